// File: rtl/dcf77_rtc.sv
// DCF77-disciplined real-time clock: free-running BCD calendar that is
// reloaded from a decoded DCF77 frame on each sync pulse.
module dcf77_rtc #(
   parameter int TICKS_PER_SEC = 100,
   parameter int HOLDOVER_MIN  = 60
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        clk_en,
   input  logic [58:0] data_hold,
   input  logic        sync,
   output logic [6:0]  second,
   output logic [6:0]  minute,
   output logic [5:0]  hour,
   output logic [5:0]  day,
   output logic [2:0]  weekday,
   output logic [4:0]  month,
   output logic [7:0]  year,
   output logic        dst,
   output logic        valid,
   output logic        sec_tick
);

   localparam logic [6:0] PRE_MAX  = 7'(TICKS_PER_SEC - 1);
   localparam logic [7:0] HOLD_LIM = 8'(HOLDOVER_MIN);

   logic [6:0] prescaler, prescaler_n;
   logic [7:0] holdover, holdover_n;
   logic       synced, synced_n;

   logic [6:0] second_n, minute_n;
   logic [5:0] hour_n, day_n, last_day;
   logic [2:0] weekday_n;
   logic [4:0] month_n;
   logic [7:0] year_n;
   logic       dst_n, valid_n, tick_n;
   logic       wrap, leap;
   logic       sec_c, min_c, hour_c, day_c, mon_c;

   // Divisible by 4 expressed on the two BCD digits directly
   assign leap = year[4] ? (year[3:0] == 4'd2 || year[3:0] == 4'd6)
                         : (year[3:0] == 4'd0 || year[3:0] == 4'd4 ||
                            year[3:0] == 4'd8);

   always_comb begin
      last_day = 6'h31;
      case (month)
         5'h02: last_day = leap ? 6'h29 : 6'h28;
         5'h04, 5'h06, 5'h09, 5'h11: last_day = 6'h30;
         default: last_day = 6'h31;
      endcase
   end

   assign wrap   = clk_en && (prescaler == PRE_MAX);
   assign sec_c  = wrap && (second == 7'h59);
   assign min_c  = sec_c && (minute == 7'h59);
   assign hour_c = min_c && (hour == 6'h23);
   assign day_c  = hour_c && (day == last_day);
   assign mon_c  = day_c && (month == 5'h12);

   always_comb begin
      prescaler_n = prescaler;
      holdover_n  = holdover;
      synced_n    = synced;
      second_n    = second;
      minute_n    = minute;
      hour_n      = hour;
      day_n       = day;
      weekday_n   = weekday;
      month_n     = month;
      year_n      = year;
      dst_n       = dst;
      tick_n      = 1'b0;

      if (sync) begin
         minute_n    = data_hold[27:21];
         hour_n      = data_hold[34:29];
         day_n       = data_hold[41:36];
         weekday_n   = data_hold[44:42];
         month_n     = data_hold[49:45];
         year_n      = data_hold[57:50];
         dst_n       = data_hold[17];
         second_n    = 7'h00;
         prescaler_n = 7'd0;
         holdover_n  = 8'd0;
         synced_n    = 1'b1;
      end else begin
         if (clk_en)
            prescaler_n = wrap ? 7'd0 : prescaler + 7'd1;
         if (wrap) begin
            tick_n = 1'b1;
            if (sec_c)
               second_n = 7'h00;
            else if (second[3:0] == 4'd9)
               second_n = {second[6:4] + 3'd1, 4'd0};
            else
               second_n = second + 7'd1;
         end
         if (sec_c) begin
            if (holdover != 8'hff)
               holdover_n = holdover + 8'd1;
            if (min_c)
               minute_n = 7'h00;
            else if (minute[3:0] == 4'd9)
               minute_n = {minute[6:4] + 3'd1, 4'd0};
            else
               minute_n = minute + 7'd1;
         end
         if (min_c) begin
            if (hour_c)
               hour_n = 6'h00;
            else if (hour[3:0] == 4'd9)
               hour_n = {hour[5:4] + 2'd1, 4'd0};
            else
               hour_n = hour + 6'd1;
         end
         if (hour_c) begin
            weekday_n = (weekday == 3'd7) ? 3'd1 : weekday + 3'd1;
            if (day_c)
               day_n = 6'h01;
            else if (day[3:0] == 4'd9)
               day_n = {day[5:4] + 2'd1, 4'd0};
            else
               day_n = day + 6'd1;
         end
         if (day_c) begin
            if (mon_c)
               month_n = 5'h01;
            else if (month[3:0] == 4'd9)
               month_n = 5'h10;
            else
               month_n = month + 5'd1;
         end
         if (mon_c) begin
            if (year == 8'h99)
               year_n = 8'h00;
            else if (year[3:0] == 4'd9)
               year_n = {year[7:4] + 4'd1, 4'd0};
            else
               year_n = year + 8'd1;
         end
      end

      valid_n = synced_n && (holdover_n < HOLD_LIM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler <= 7'd0;
         holdover  <= 8'd0;
         synced    <= 1'b0;
         second    <= 7'h00;
         minute    <= 7'h00;
         hour      <= 6'h00;
         day       <= 6'h01;
         weekday   <= 3'd6;
         month     <= 5'h01;
         year      <= 8'h00;
         dst       <= 1'b0;
         valid     <= 1'b0;
         sec_tick  <= 1'b0;
      end else begin
         prescaler <= prescaler_n;
         holdover  <= holdover_n;
         synced    <= synced_n;
         second    <= second_n;
         minute    <= minute_n;
         hour      <= hour_n;
         day       <= day_n;
         weekday   <= weekday_n;
         month     <= month_n;
         year      <= year_n;
         dst       <= dst_n;
         valid     <= valid_n;
         sec_tick  <= tick_n;
      end
   end

endmodule

// File: tb/tb_dcf77_rtc.sv
// Self-checking bench for dcf77_rtc against a calendar model kept in
// plain integers (seconds, minutes, days-in-month arithmetic).
module tb_dcf77_rtc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b0;
   logic        sync = 1'b0;
   logic [58:0] data_hold = '0;
   logic [6:0]  second, minute;
   logic [5:0]  hour, day;
   logic [2:0]  weekday;
   logic [4:0]  month;
   logic [7:0]  year;
   logic        dst, valid, sec_tick;

   dcf77_rtc #(.TICKS_PER_SEC(100), .HOLDOVER_MIN(2)) dut (
      .rst(rst), .clk(clk), .clk_en(clk_en), .data_hold(data_hold),
      .sync(sync), .second(second), .minute(minute), .hour(hour),
      .day(day), .weekday(weekday), .month(month), .year(year),
      .dst(dst), .valid(valid), .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ticks  = 0;

   int m_pre, m_sec, m_min, m_hr, m_day, m_wd, m_mon, m_yr, m_hold;
   bit m_dst, m_synced, m_tick;
   int l_min, l_hr, l_day, l_wd, l_mon, l_yr;
   bit l_dst;

   function automatic int bcd(input int v);
      return (v / 10) * 16 + v % 10;
   endfunction

   function automatic int dim(input int mo, input int yr);
      if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
      if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
      return 31;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pre = 0; m_sec = 0; m_min = 0; m_hr = 0; m_day = 1; m_wd = 6;
      m_mon = 1; m_yr = 0; m_dst = 0; m_synced = 0; m_hold = 0;
      m_tick = 0;
   endtask

   task automatic adv_second();
      m_sec++;
      if (m_sec < 60) return;
      m_sec = 0;
      m_min++;
      if (m_hold < 255) m_hold++;
      if (m_min < 60) return;
      m_min = 0;
      m_hr++;
      if (m_hr < 24) return;
      m_hr = 0;
      m_wd = m_wd % 7 + 1;
      m_day++;
      if (m_day <= dim(m_mon, m_yr)) return;
      m_day = 1;
      m_mon++;
      if (m_mon < 13) return;
      m_mon = 1;
      m_yr = (m_yr + 1) % 100;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".sec"}, 32'(second), 32'(bcd(m_sec)));
      chk({tag, ".min"}, 32'(minute), 32'(bcd(m_min)));
      chk({tag, ".hour"}, 32'(hour), 32'(bcd(m_hr)));
      chk({tag, ".day"}, 32'(day), 32'(bcd(m_day)));
      chk({tag, ".wday"}, 32'(weekday), 32'(m_wd));
      chk({tag, ".mon"}, 32'(month), 32'(bcd(m_mon)));
      chk({tag, ".year"}, 32'(year), 32'(bcd(m_yr)));
      chk({tag, ".dst"}, 32'(dst), 32'(m_dst));
      chk({tag, ".valid"}, 32'(valid), 32'(m_synced && m_hold < 2));
   endtask

   task automatic load(input int mi, input int hr, input int dy,
                       input int wd, input int mo, input int yr,
                       input bit ds);
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      data_hold = r[58:0];
      data_hold[27:21] = 7'(bcd(mi));
      data_hold[34:29] = 6'(bcd(hr));
      data_hold[41:36] = 6'(bcd(dy));
      data_hold[44:42] = 3'(wd);
      data_hold[49:45] = 5'(bcd(mo));
      data_hold[57:50] = 8'(bcd(yr));
      data_hold[17] = ds;
      l_min = mi; l_hr = hr; l_day = dy; l_wd = wd;
      l_mon = mo; l_yr = yr; l_dst = ds;
   endtask

   task automatic load_random();
      int mo, yr;
      mo = $urandom_range(1, 12);
      yr = $urandom_range(0, 99);
      load($urandom_range(0, 59), $urandom_range(0, 23),
           $urandom_range(1, dim(mo, yr)), $urandom_range(1, 7),
           mo, yr, 1'($urandom_range(0, 1)));
   endtask

   task automatic cyc(input bit en, input bit sy);
      clk_en = en;
      sync = sy;
      @(posedge clk);
      #1;
      m_tick = 0;
      if (sy) begin
         m_sec = 0; m_min = l_min; m_hr = l_hr; m_day = l_day;
         m_wd = l_wd; m_mon = l_mon; m_yr = l_yr; m_dst = l_dst;
         m_pre = 0; m_hold = 0; m_synced = 1;
      end else if (en) begin
         m_pre++;
         if (m_pre == 100) begin
            m_pre = 0;
            m_tick = 1;
            adv_second();
         end
      end
      clk_en = 1'b0;
      sync = 1'b0;
      if (sec_tick) ticks++;
      chk("sec_tick", 32'(sec_tick), 32'(m_tick));
      if (m_tick || sy) check_state("run");
   endtask

   task automatic pulses(input int n);
      repeat (n) begin
         cyc(1'b1, 1'b0);
         cyc(1'b0, 1'b0);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_state("reset");
      chk("reset.tick", 32'(sec_tick), 32'd0);
      rst = 1'b0;
      ticks = 0;

      // One second after reset
      pulses(100);
      chk("first_sec.ticks", 32'(ticks), 32'd1);
      chk("first_sec.sec", 32'(second), 32'h01);
      chk("first_sec.valid", 32'(valid), 32'd0);

      // Century rollover with weekday wrap
      load(59, 23, 31, 7, 12, 99, 1'b0);
      cyc(1'b0, 1'b1);
      chk("y2k.valid0", 32'(valid), 32'd1);
      pulses(6000);
      chk("y2k.hour", 32'(hour), 32'h00);
      chk("y2k.min", 32'(minute), 32'h00);
      chk("y2k.day", 32'(day), 32'h01);
      chk("y2k.mon", 32'(month), 32'h01);
      chk("y2k.year", 32'(year), 32'h00);
      chk("y2k.wday", 32'(weekday), 32'd1);

      // Leap and non-leap February; first sync coincides with clk_en
      load(59, 23, 28, $urandom_range(1, 7), 2, 24, 1'b1);
      cyc(1'b1, 1'b1);
      pulses(6000);
      chk("leap.day", 32'(day), 32'h29);
      chk("leap.mon", 32'(month), 32'h02);
      load(59, 23, 28, $urandom_range(1, 7), 2, 23, 1'b0);
      cyc(1'b0, 1'b1);
      pulses(6000);
      chk("noleap.day", 32'(day), 32'h01);
      chk("noleap.mon", 32'(month), 32'h03);

      // Holdover expiry exactly at the second minute carry
      load_random();
      cyc(1'b0, 1'b1);
      pulses(11999);
      chk("hold.before", 32'(valid), 32'd1);
      pulses(1);
      chk("hold.after", 32'(valid), 32'd0);

      // Sync on the prescaler wrap at second 59 wins over the carry
      pulses(5999);
      chk("race.sec59", 32'(second), 32'h59);
      load_random();
      cyc(1'b1, 1'b1);
      chk("race.sec", 32'(second), 32'h00);
      chk("race.min", 32'(minute), 32'(bcd(l_min)));
      chk("race.tick", 32'(sec_tick), 32'd0);
      chk("race.valid", 32'(valid), 32'd1);

      // Random loads with short runs
      repeat (4) begin
         load_random();
         cyc(1'($urandom_range(0, 1)), 1'b1);
         pulses($urandom_range(50, 400));
      end

      // Asynchronous reset between clock edges
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_state("areset");
      chk("areset.tick", 32'(sec_tick), 32'd0);
      #1;
      rst = 1'b0;
      ticks = 0;
      pulses(100);
      chk("resume.ticks", 32'(ticks), 32'd1);
      chk("resume.sec", 32'(second), 32'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
